onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning RAM data width; BE_W = DATA_W/8 is derived.
REQ-003 SHALL have ports clk (in, 1, sole clock) and reset_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have ports m0_address (in, ADDR_W), m0_byteenable (in, BE_W), m0_read (in, 1) and m0_write (in, 1), carrying requester 0's command.
REQ-005 SHALL have ports m0_writedata (in, DATA_W), m0_readdata (out, DATA_W), m0_waitrequest (out, 1) and m0_readdatavalid (out, 1), carrying requester 0's data and handshake.
REQ-006 SHALL have an identical port set m1_* for requester 1.
REQ-007 SHALL have ports mem_address (out, ADDR_W), mem_byteenable (out, BE_W), mem_chipselect (out, 1), mem_write (out, 1) and mem_writedata (out, DATA_W) driving the single-port RAM.
REQ-008 SHALL have ports mem_readdata (in, DATA_W, RAM read data) and mem_clken (out, 1, RAM clock enable).
REQ-009 SHALL have ports clear_start (in, 1, zero-fill request pulse), clear_busy (out, 1) and clear_done (out, 1, one-cycle pulse).

Function
REQ-010 SHALL drive mem_clken constant 1.
REQ-011 SHALL treat a requester as requesting when its read or write input is 1.
REQ-012 SHALL grant at most one requester per cycle, combinationally.
REQ-013 SHALL give the grant to the sole requester when only one requests.
REQ-014 SHALL give the grant to the requester not granted most recently when both request, with a last-grant pointer updated only on a grant.
REQ-015 SHALL drive mx_waitrequest = mx_request AND NOT granted, and 1 for both requesters while clear_busy=1.
REQ-016 SHALL pass the granted requester's address, byteenable and writedata to mem_* with mem_chipselect=1, in the same cycle.
REQ-017 SHALL set mem_write=1 for a granted write and mem_chipselect=0 when nothing is granted.
REQ-018 SHALL treat read and write both high as a write: no readdatavalid is produced.
REQ-019 SHALL have read latency 1: mx_readdatavalid=1 exactly in the cycle after a granted read, with mx_readdata=mem_readdata in that cycle.
REQ-020 SHALL route mem_readdata to both mx_readdata continuously; only readdatavalid is steered.
REQ-021 SHALL allow back-to-back granted reads, one per cycle, with no bubble.
REQ-022 SHALL implement FSM IDLE -> CLEAR -> DONE -> IDLE.
REQ-023 In IDLE, SHALL enter CLEAR on the cycle after clear_start=1; an access granted in the same cycle as clear_start completes normally.
REQ-024 In CLEAR, SHALL write zero with byteenable all-ones to address cnt, cnt starting at 0 and incrementing each cycle.
REQ-025 SHALL go from CLEAR to DONE after writing cnt = 2^ADDR_W-1, which is 2^ADDR_W cycles in CLEAR.
REQ-026 In DONE, SHALL assert clear_done for one cycle, then return to IDLE.
REQ-027 SHALL assert clear_busy exactly while in CLEAR.
REQ-028 SHALL ignore clear_start outside IDLE.
REQ-029 SHALL have cnt wrap to 0 on the final write without overflow into other state.

Reset
REQ-030 While reset_n=0, SHALL hold the FSM in IDLE and cnt=0.
REQ-031 While reset_n=0, SHALL hold the last-grant pointer at 1, giving requester 0 priority on the first contention.
REQ-032 While reset_n=0, SHALL hold both readdatavalid=0, clear_busy=0, clear_done=0, mem_chipselect=0 and mem_write=0, and grant nothing.
REQ-033 On reset mid-clear, SHALL abort the clear immediately and drop any pending readdatavalid; deassertion resumes in IDLE.

Structure
REQ-034 SHALL place ADDR_W/DATA_W defaults, the FSM state enum and a zero-data constant in shared package onchip_mem_arb_pkg.
REQ-035 SHALL implement grant and pointer logic in sub-module rr_arbiter2 (inputs req[1:0], outputs gnt[1:0]; pointer register inside).

Verification
REQ-036 SHALL cover: m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then reads 0x0010 -> m0_readdatavalid one cycle after the read grant with data 0xDEADBEEF.
REQ-037 SHALL cover: m0 and m1 both read continuously for 4 cycles after reset -> grants m0, m1, m0, m1, and each waitrequest is high on the other's cycles.
REQ-038 SHALL cover: m1 writes byteenable 0x3 of 0x12345678 over 0xFFFFFFFF at 0x7FFF, then reads -> 0xFFFF5678.
REQ-039 SHALL cover: clear_start pulse -> clear_busy high for 32768 cycles, clear_done one pulse, requester waitrequests held high throughout, and any read afterwards returns 0.
REQ-040 SHALL cover: reset_n low at cnt=100 during a clear -> outputs take reset values immediately, the FSM is in IDLE after release, and address 99 reads 0.
REQ-041 SHALL cover: read and write both high on m0 -> write performed and no m0_readdatavalid.

Source files
------------

// File: rtl/onchip_mem_arb_pkg.sv
// Shared definitions for the two-requester on-chip RAM arbiter.
package onchip_mem_arb_pkg;

   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 32;

   // Zero-fill engine states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } clr_state_e;

   // Pattern written to every word during a zero-fill
   localparam logic [DATA_W_DEF-1:0] ZERO_DATA = '0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // last_q = index of the requester granted most recently
   logic last_q;
   logic last_d;

   // Grant the sole requester, or the one not granted last time on contention
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Pointer moves only when a grant is actually issued
   always_comb begin
      last_d = last_q;
      if (gnt[0]) begin
         last_d = 1'b0;
      end else if (gnt[1]) begin
         last_d = 1'b1;
      end
   end

   // Pointer register; reset to 1 so requester 0 wins the first contention
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates two requesters onto one single-port RAM and adds a zero-fill engine
// that takes the RAM over for 2^ADDR_W cycles when clear_start is pulsed.
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   // requester 0
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_waitrequest,
   output logic                  m0_readdatavalid,
   // requester 1
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_waitrequest,
   output logic                  m1_readdatavalid,
   // RAM side
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata,
   output logic                  mem_clken,
   // zero-fill control
   input  logic                  clear_start,
   output logic                  clear_busy,
   output logic                  clear_done
);

   localparam int BE_W = DATA_W / 8;

   clr_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [1:0]          rdv_q, rdv_d;
   logic [1:0]          req;
   logic [1:0]          req_arb;
   logic [1:0]          gnt;

   assign mem_clken  = 1'b1;
   assign clear_busy = (state_q == ST_CLEAR);
   assign clear_done = (state_q == ST_DONE);

   // Read data is broadcast; only the valid strobe is steered
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = rdv_q[0];
   assign m1_readdatavalid = rdv_q[1];

   assign req = {m1_read | m1_write, m0_read | m0_write};
   // No requester may win while the clear owns the RAM or while in reset
   assign req_arb = req & {2{~clear_busy & reset_n}};

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_arb),
      .gnt     (gnt)
   );

   assign m0_waitrequest = clear_busy | (req[0] & ~gnt[0]);
   assign m1_waitrequest = clear_busy | (req[1] & ~gnt[1]);

   // RAM command mux: clear engine first, then whichever requester holds the grant
   always_comb begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      if (clear_busy) begin
         mem_address    = cnt_q;
         mem_byteenable = {BE_W{1'b1}};
         mem_chipselect = 1'b1;
         mem_write      = 1'b1;
         mem_writedata  = DATA_W'(ZERO_DATA);
      end else if (gnt[0]) begin
         mem_address    = m0_address;
         mem_byteenable = m0_byteenable;
         mem_chipselect = 1'b1;
         mem_write      = m0_write;
         mem_writedata  = m0_writedata;
      end else if (gnt[1]) begin
         mem_address    = m1_address;
         mem_byteenable = m1_byteenable;
         mem_chipselect = 1'b1;
         mem_write      = m1_write;
         mem_writedata  = m1_writedata;
      end
   end

   // A granted pure read returns data next cycle; read+write counts as a write
   always_comb begin
      rdv_d = {gnt[1] & m1_read & ~m1_write,
               gnt[0] & m0_read & ~m0_write};
   end

   // Zero-fill sequencer: walk every address once, then pulse done
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_start) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            // Counter wraps to 0 naturally on the last address
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter and read-valid registers; reset aborts any clear in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdv_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdv_q   <= rdv_d;
      end
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM and a read scoreboard.
module tb_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [14:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [14:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        clear_start, clear_busy, clear_done;

   int n_compared = 0;
   int n_mismatch = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(15), .DATA_W(32)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_readdata      (m0_readdata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_readdata      (m1_readdata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_readdata     (mem_readdata),
      .mem_clken        (mem_clken),
      .clear_start      (clear_start),
      .clear_busy       (clear_busy),
      .clear_done       (clear_done)
   );

   // Behavioural single-port RAM, registered read, byte-enabled write
   logic [31:0] ram [0:32767];
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         mem_readdata <= ram[mem_address];
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatch++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: pop and compare whenever a requester sees readdatavalid
   always @(negedge clk) begin
      if (m0_readdatavalid) begin
         if (q0.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL m0_unexpected_rdv: readdatavalid=1 data=%h, expected no response", m0_readdata);
         end else begin
            check("m0_readdata", m0_readdata, q0.pop_front());
         end
      end
      if (m1_readdatavalid) begin
         if (q1.size() == 0) begin
            n_compared++;
            n_mismatch++;
            $display("FAIL m1_unexpected_rdv: readdatavalid=1 data=%h, expected no response", m1_readdata);
         end else begin
            check("m1_readdata", m1_readdata, q1.pop_front());
         end
      end
   end

   task automatic drive(input int port, input logic rd, input logic wr, input logic [14:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      if (port == 0) begin
         m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = wd;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = wd;
      end
   endtask

   // One access, called just after a rising edge; returns just after a rising edge
   task automatic access(input int port, input logic rd, input logic wr, input logic [14:0] addr,
                         input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp_rd);
      bit granted = 0;
      drive(port, rd, wr, addr, be, wd);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if ((port == 0 ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
            granted = 1;
            if (rd && !wr) begin
               if (port == 0) q0.push_back(exp_rd); else q1.push_back(exp_rd);
            end
            break;
         end
      end
      if (!granted) begin
         n_compared++;
         n_mismatch++;
         $display("FAIL grant_timeout: m%0d waitrequest=1 after 50 cycles, expected 0", port);
      end
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      if (rd) begin
         @(negedge clk);
         check(port == 0 ? "m0_rdv_after_grant" : "m1_rdv_after_grant",
               {31'd0, (port == 0 ? m0_readdatavalid : m1_readdatavalid)},
               {31'd0, !wr});
         @(posedge clk); #1;
      end
   endtask

   int  busy_cnt, bad_wait, bad_wr, bad_done;
   bit  found;

   initial begin
      reset_n = 1'b0;
      clear_start = 1'b0;
      drive(0, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      drive(1, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      // Reset values, with a request pending that must not be granted
      m0_read = 1'b1; m0_address = 15'd5;
      @(negedge clk);
      check("rst_chipselect", {31'd0, mem_chipselect}, 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
      check("rst_clear_done", {31'd0, clear_done}, 32'd0);
      check("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
      check("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
      check("clken", {31'd0, mem_clken}, 32'd1);
      m0_read = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Seed data for the contention test, then reset to restore the pointer
      access(0, 1'b0, 1'b1, 15'h0020, 4'hF, 32'hA000_0020, 32'd0);
      access(1, 1'b0, 1'b1, 15'h0021, 4'hF, 32'hA000_0021, 32'd0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Both read continuously: m0, m1, m0, m1
      drive(0, 1'b1, 1'b0, 15'h0020, 4'hF, 32'd0);
      drive(1, 1'b1, 1'b0, 15'h0021, 4'hF, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rr%0d_m0_wait", i), {31'd0, m0_waitrequest}, {31'd0, (i % 2) == 1});
         check($sformatf("rr%0d_m1_wait", i), {31'd0, m1_waitrequest}, {31'd0, (i % 2) == 0});
         if ((i % 2) == 0) q0.push_back(32'hA000_0020); else q1.push_back(32'hA000_0021);
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      drive(1, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      @(posedge clk); #1;

      // Write then read back
      access(0, 1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEAD_BEEF, 32'd0);
      access(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'd0, 32'hDEAD_BEEF);

      // Partial byte write at the top address
      access(1, 1'b0, 1'b1, 15'h7FFF, 4'hF, 32'hFFFF_FFFF, 32'd0);
      access(1, 1'b0, 1'b1, 15'h7FFF, 4'h3, 32'h1234_5678, 32'd0);
      access(1, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'd0, 32'hFFFF_5678);

      // Read and write together is a write with no response
      access(0, 1'b1, 1'b1, 15'h0030, 4'hF, 32'hCAFE_F00D, 32'd0);
      access(0, 1'b1, 1'b0, 15'h0030, 4'hF, 32'd0, 32'hCAFE_F00D);

      // Zero-fill; a read granted alongside clear_start completes normally
      clear_start = 1'b1;
      drive(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'd0);
      @(negedge clk);
      check("clr_start_grant_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
      q0.push_back(32'hDEAD_BEEF);
      @(posedge clk); #1;
      clear_start = 1'b0;
      drive(0, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      drive(1, 1'b1, 1'b0, 15'h0021, 4'hF, 32'd0);
      busy_cnt = 0; bad_wait = 0; bad_wr = 0; bad_done = 0;
      for (int c = 0; c < 40000; c++) begin
         @(negedge clk);
         if (!clear_busy) break;
         if (!m0_waitrequest || !m1_waitrequest) bad_wait++;
         if (mem_address !== busy_cnt[14:0] || mem_write !== 1'b1 || mem_chipselect !== 1'b1 ||
             mem_writedata !== 32'd0 || mem_byteenable !== 4'hF) bad_wr++;
         if (clear_done) bad_done++;
         busy_cnt++;
         clear_start = (busy_cnt == 1000);
      end
      clear_start = 1'b0;
      check("clr_busy_cycles", busy_cnt, 32'd32768);
      check("clr_wait_violations", bad_wait, 32'd0);
      check("clr_write_violations", bad_wr, 32'd0);
      check("clr_done_early", bad_done, 32'd0);
      check("clr_done_pulse", {31'd0, clear_done}, 32'd1);
      check("clr_done_m1_grant", {31'd0, m1_waitrequest}, 32'd0);
      q1.push_back(32'd0);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      @(negedge clk);
      check("clr_done_one_cycle", {31'd0, clear_done}, 32'd0);
      check("clr_no_restart", {31'd0, clear_busy}, 32'd0);
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'd0, 32'd0);
      access(1, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'd0, 32'd0);

      // Reset in the middle of a clear at cnt=100
      access(0, 1'b0, 1'b1, 15'd99, 4'hF, 32'h1111_1111, 32'd0);
      access(0, 1'b0, 1'b1, 15'd100, 4'hF, 32'h2222_2222, 32'd0);
      clear_start = 1'b1;
      @(posedge clk); #1;
      clear_start = 1'b0;
      found = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (clear_busy && mem_address == 15'd100) begin
            found = 1;
            break;
         end
      end
      if (!found) begin
         n_compared++;
         n_mismatch++;
         $display("FAIL clr_reach_100: clear never reached address 100, expected within 2000 cycles");
      end
      reset_n = 1'b0;
      #1;
      check("midclr_busy", {31'd0, clear_busy}, 32'd0);
      check("midclr_chipselect", {31'd0, mem_chipselect}, 32'd0);
      check("midclr_mem_write", {31'd0, mem_write}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("midclr_idle_after", {30'd0, clear_busy, clear_done}, 32'd0);
      @(posedge clk); #1;
      access(0, 1'b1, 1'b0, 15'd99, 4'hF, 32'd0, 32'd0);
      access(0, 1'b1, 1'b0, 15'd100, 4'hF, 32'd0, 32'h2222_2222);

      // Reset after a read grant drops the pending readdatavalid
      drive(0, 1'b1, 1'b0, 15'h0030, 4'hF, 32'd0);
      @(negedge clk);
      check("drop_rdv_grant", {31'd0, m0_waitrequest}, 32'd0);
      reset_n = 1'b0;
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 15'd0, 4'h0, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("drop_rdv", {31'd0, m0_readdatavalid}, 32'd0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drain", q0.size() + q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
